// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM states and constants for the alu_mdu_seq
// multiply/divide sequencer and its step logic.
package mdu_pkg;

    // Datapath ALU opcodes; must match the encoding of the shared ALU.
    localparam logic [3:0] ADD_OP = 4'b0000;
    localparam logic [3:0] SUB_OP = 4'b0001;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int         LP_ITERS    = 32;
    localparam logic [5:0] LP_CNT_LAST = 6'(LP_ITERS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP_A = 3'd1,
        PREP_B = 3'd2,
        ITER   = 3'd3,
        FIX    = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Result lives in acc for MULH*/REM*, in mq for MUL/DIV*.
    function automatic logic f_sel_acc(input logic [2:0] op);
        return op[2] ? op[1] : (op[1:0] != 2'b00);
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV, REM.
    function automatic logic f_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV, REM (not MULHSU).
    function automatic logic f_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: combinational single-step logic. Produces the ALU drive for one
// shift-add multiply or restoring divide step and, from the ALU's same-cycle
// result and carry, the next acc/mq values.
module mdu_step
    import mdu_pkg::*;
(
    input  logic        i_div,
    input  logic [31:0] i_acc,
    input  logic [31:0] i_mq,
    input  logic [31:0] i_md,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_carry,
    output logic [3:0]  o_alu_ctrl,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [31:0] o_acc_nxt,
    output logic [31:0] o_mq_nxt
);

    logic [31:0] w_rs;
    logic        w_qbit;

    // One step: divide shifts-and-trial-subtracts, multiply adds-and-shifts.
    // The md==0 term is needed because the ALU reports no carry for x - 0.
    always_comb begin
        w_rs   = {i_acc[30:0], i_mq[31]};
        w_qbit = i_acc[31] | i_alu_carry | (i_md == 32'd0);
        if (i_div) begin
            o_alu_ctrl = SUB_OP;
            o_alu_a    = w_rs;
            o_alu_b    = i_md;
            o_acc_nxt  = w_qbit ? i_alu_result : w_rs;
            o_mq_nxt   = {i_mq[30:0], w_qbit};
        end else begin
            o_alu_ctrl = ADD_OP;
            o_alu_a    = i_acc;
            o_alu_b    = i_mq[0] ? i_md : 32'd0;
            o_acc_nxt  = {i_alu_carry, i_alu_result[31:1]};
            o_mq_nxt   = {i_alu_result[0], i_mq[31:1]};
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: multi-cycle RV32M multiply/divide sequencer that borrows the
// shared datapath ALU for all of its arithmetic (32 iterations).
// Optional feature macro: MDU_SIGNED_EN adds PREP_A/PREP_B (operand negation)
// and FIX (result negation) states for the signed ops; without it the signed
// ops run as their unsigned counterparts.
//
// Handshake: istart is accepted only on a clock edge where the block is IDLE
// (obusy low) and iflush is low; iop/isrc_a/isrc_b are sampled on that edge.
// obusy is high from the cycle after accept until DONE returns to IDLE.
// ovalid pulses for exactly one cycle with oresult valid; oresult then holds
// until the next completion. iflush aborts synchronously, no ovalid follows.
module alu_mdu_seq
    import mdu_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     istart,
    input  logic [2:0]               iop,
    input  logic [MP_DATA_WIDTH-1:0] isrc_a,
    input  logic [MP_DATA_WIDTH-1:0] isrc_b,
    input  logic                     iflush,
    output logic                     obusy,
    output logic                     ovalid,
    output logic [MP_DATA_WIDTH-1:0] oresult,
    output logic [3:0]               oalu_ctrl,
    output logic [MP_DATA_WIDTH-1:0] oalu_src_a,
    output logic [MP_DATA_WIDTH-1:0] oalu_src_b,
    input  logic [MP_DATA_WIDTH-1:0] ialu_result,
    input  logic                     ialu_carry,
    output state_t                   odbg_state
);

    state_t      r_state;
    logic [31:0] r_acc;
    logic [31:0] r_mq;
    logic [31:0] r_md;
    logic [5:0]  r_cnt;
    logic [2:0]  r_op;
    logic        r_obusy;
    logic        r_ovalid;
    logic [31:0] r_oresult;
`ifdef MDU_SIGNED_EN
    logic        r_neg_a;
    logic        r_neg_b;
    logic [31:0] w_sel;
`endif

    logic [3:0]  w_step_ctrl;
    logic [31:0] w_step_a;
    logic [31:0] w_step_b;
    logic [31:0] w_acc_nxt;
    logic [31:0] w_mq_nxt;
    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;

    mdu_step u_step (
        .i_div        (r_op[2]),
        .i_acc        (r_acc),
        .i_mq         (r_mq),
        .i_md         (r_md),
        .i_alu_result (ialu_result),
        .i_alu_carry  (ialu_carry),
        .o_alu_ctrl   (w_step_ctrl),
        .o_alu_a      (w_step_a),
        .o_alu_b      (w_step_b),
        .o_acc_nxt    (w_acc_nxt),
        .o_mq_nxt     (w_mq_nxt)
    );

    // ALU drive per state; ADD 0+0 whenever the ALU is not needed.
    always_comb begin
        w_alu_ctrl = ADD_OP;
        w_alu_a    = 32'd0;
        w_alu_b    = 32'd0;
`ifdef MDU_SIGNED_EN
        w_sel      = f_sel_acc(r_op) ? r_acc : r_mq;
`endif
        case (r_state)
            ITER: begin
                w_alu_ctrl = w_step_ctrl;
                w_alu_a    = w_step_a;
                w_alu_b    = w_step_b;
            end
`ifdef MDU_SIGNED_EN
            PREP_A: if (r_neg_a) begin
                w_alu_ctrl = SUB_OP;
                w_alu_b    = r_mq;
            end
            PREP_B: if (r_neg_b) begin
                w_alu_ctrl = SUB_OP;
                w_alu_b    = r_md;
            end
            FIX: begin
                // Default is a pass-through (sel + 0); negations use 0 - x.
                w_alu_a = w_sel;
                if (((r_op == OP_MULH) || (r_op == OP_MULHSU)) && (r_neg_a ^ r_neg_b)) begin
                    // High word of -{acc,mq}: ~acc + (mq == 0)
                    w_alu_ctrl = SUB_OP;
                    w_alu_a    = (r_mq == 32'd0) ? 32'd0 : 32'hFFFF_FFFF;
                    w_alu_b    = r_acc;
                end else if ((r_op == OP_DIV) && (r_neg_a ^ r_neg_b) && (r_md != 32'd0)) begin
                    w_alu_ctrl = SUB_OP;
                    w_alu_a    = 32'd0;
                    w_alu_b    = r_mq;
                end else if ((r_op == OP_REM) && r_neg_a) begin
                    w_alu_ctrl = SUB_OP;
                    w_alu_a    = 32'd0;
                    w_alu_b    = r_acc;
                end
            end
`endif
            default: ;
        endcase
    end

    // Sequencer FSM with registered busy/valid/result; flush overrides all.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state   <= IDLE;
            r_acc     <= 32'd0;
            r_mq      <= 32'd0;
            r_md      <= 32'd0;
            r_cnt     <= 6'd0;
            r_op      <= 3'd0;
            r_obusy   <= 1'b0;
            r_ovalid  <= 1'b0;
            r_oresult <= 32'd0;
`ifdef MDU_SIGNED_EN
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
`endif
        end else begin
            r_ovalid <= 1'b0;
            if (iflush) begin
                r_state <= IDLE;
                r_obusy <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (istart) begin
                        r_acc   <= 32'd0;
                        r_mq    <= isrc_a;
                        r_md    <= isrc_b;
                        r_cnt   <= 6'd0;
                        r_op    <= iop;
                        r_obusy <= 1'b1;
`ifdef MDU_SIGNED_EN
                        r_neg_a <= f_signed_a(iop) & isrc_a[31];
                        r_neg_b <= f_signed_b(iop) & isrc_b[31];
                        r_state <= PREP_A;
`else
                        r_state <= ITER;
`endif
                    end
`ifdef MDU_SIGNED_EN
                    PREP_A: begin
                        if (r_neg_a) r_mq <= ialu_result;
                        r_state <= PREP_B;
                    end
                    PREP_B: begin
                        if (r_neg_b) r_md <= ialu_result;
                        r_state <= ITER;
                    end
                    FIX: begin
                        r_oresult <= ialu_result;
                        r_ovalid  <= 1'b1;
                        r_state   <= DONE;
                    end
`endif
                    ITER: begin
                        r_acc <= w_acc_nxt;
                        r_mq  <= w_mq_nxt;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == LP_CNT_LAST) begin
`ifdef MDU_SIGNED_EN
                            r_state   <= FIX;
`else
                            r_oresult <= f_sel_acc(r_op) ? w_acc_nxt : w_mq_nxt;
                            r_ovalid  <= 1'b1;
                            r_state   <= DONE;
`endif
                        end
                    end
                    DONE: begin
                        r_obusy <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign obusy      = r_obusy;
    assign ovalid     = r_ovalid;
    assign oresult    = r_oresult;
    assign oalu_ctrl  = w_alu_ctrl;
    assign oalu_src_a = w_alu_a;
    assign oalu_src_b = w_alu_b;
    assign odbg_state = r_state;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: bench for alu_mdu_seq with a behavioural ALU beside it.
// Expected results come from an arithmetic RV32M model (64-bit products,
// native division); build with MDU_SIGNED_EN to cover the signed ops.
module tb_alu_mdu_seq;
    import mdu_pkg::*;

`ifdef MDU_SIGNED_EN
    localparam int LAT_EDGE = 35;
`else
    localparam int LAT_EDGE = 32;
`endif

    // ---------------- clock / reset / signals ----------------
    logic        iclk = 1'b0;
    logic        irst_n;
    logic        istart;
    logic [2:0]  iop;
    logic [31:0] isrc_a;
    logic [31:0] isrc_b;
    logic        iflush;
    logic        obusy;
    logic        ovalid;
    logic [31:0] oresult;
    logic [3:0]  oalu_ctrl;
    logic [31:0] oalu_src_a;
    logic [31:0] oalu_src_b;
    logic [31:0] ialu_result;
    logic        ialu_carry;
    state_t      dbg_state;

    always #5 iclk = ~iclk;

    // Shared datapath ALU: SUB carry is the carry out of a + (-b), so it is 0 for b == 0.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum     = 33'd0;
        ialu_result = 32'd0;
        ialu_carry  = 1'b0;
        if (oalu_ctrl == ADD_OP) begin
            alu_sum     = {1'b0, oalu_src_a} + {1'b0, oalu_src_b};
            ialu_result = alu_sum[31:0];
            ialu_carry  = alu_sum[32];
        end else if (oalu_ctrl == SUB_OP) begin
            ialu_result = oalu_src_a - oalu_src_b;
            ialu_carry  = (oalu_src_b != 32'd0) && (oalu_src_a >= oalu_src_b);
        end
    end

    alu_mdu_seq #(.MP_DATA_WIDTH(32)) dut (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .istart      (istart),
        .iop         (iop),
        .isrc_a      (isrc_a),
        .isrc_b      (isrc_b),
        .iflush      (iflush),
        .obusy       (obusy),
        .ovalid      (ovalid),
        .oresult     (oresult),
        .oalu_ctrl   (oalu_ctrl),
        .oalu_src_a  (oalu_src_a),
        .oalu_src_b  (oalu_src_b),
        .ialu_result (ialu_result),
        .ialu_carry  (ialu_carry),
        .odbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RV32M reference; without the signed feature signed ops are unsigned.
    function automatic logic [31:0] ref_model(input logic [2:0] op_in, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [2:0]  op;
        logic [63:0] pu;
        longint      sa;
        longint      sb;
        longint      ub;
        longint      ps;
        logic [63:0] pv;
        logic [31:0] r;
        op = op_in;
`ifndef MDU_SIGNED_EN
        if (op == OP_MULH || op == OP_MULHSU) op = OP_MULHU;
        else if (op == OP_DIV) op = OP_DIVU;
        else if (op == OP_REM) op = OP_REMU;
`endif
        pu = {32'd0, a} * {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        r  = 32'd0;
        ps = 0;
        case (op)
            OP_MUL:    r = pu[31:0];
            OP_MULH:   begin ps = sa * sb; pv = 64'(ps); r = pv[63:32]; end
            OP_MULHSU: begin ps = sa * ub; pv = 64'(ps); r = pv[63:32]; end
            OP_MULHU:  r = pu[63:32];
            OP_DIV:    if (b == 32'd0) r = 32'hFFFF_FFFF;
                       else begin ps = sa / sb; pv = 64'(ps); r = pv[31:0]; end
            OP_DIVU:   r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    if (b == 32'd0) r = a;
                       else begin ps = sa % sb; pv = 64'(ps); r = pv[31:0]; end
            default:   r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle; returns at the negedge after accept.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        istart = 1'b1;
        iop    = op;
        isrc_a = a;
        isrc_b = b;
        @(posedge iclk);
        @(negedge iclk);
        istart = 1'b0;
        iop    = 3'($urandom_range(0, 7));
        isrc_a = $urandom;
        isrc_b = $urandom;
    endtask

    // Waits (bounded) for ovalid; k counts edges since the accept edge.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        do begin
            @(posedge iclk);
            k++;
            @(negedge iclk);
        end while (!ovalid && k < 200);
    endtask

    task automatic watch_quiet(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge iclk);
            @(negedge iclk);
            if (ovalid) pulses++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int k;
        exp_q.push_back(exp);
        start_op(op, a, b);
        check({tag, ":busy"}, 32'(obusy), 32'd1);
        wait_done(0, k);
        check({tag, ":latency"}, 32'(k), 32'(LAT_EDGE));
        check({tag, ":busy_at_done"}, 32'(obusy), 32'd1);
        check({tag, ":result"}, oresult, exp_q.pop_front());
        @(posedge iclk);
        @(negedge iclk);
        check({tag, ":pulse_end"}, 32'(ovalid), 32'd0);
        check({tag, ":idle"}, 32'(obusy), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int pulses;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        irst_n = 1'b0;
        istart = 1'b0;
        iflush = 1'b0;
        iop    = 3'd0;
        isrc_a = 32'd0;
        isrc_b = 32'd0;
        repeat (3) @(negedge iclk);

        // Reset state
        check("rst_busy", 32'(obusy), 32'd0);
        check("rst_valid", 32'(ovalid), 32'd0);
        check("rst_result", oresult, 32'd0);
        check("rst_alu_ctrl", 32'(oalu_ctrl), 32'(ADD_OP));
        check("rst_alu_a", oalu_src_a, 32'd0);
        check("rst_alu_b", oalu_src_b, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        irst_n = 1'b1;
        @(negedge iclk);

        // Directed cases
        run_op(OP_MUL,   32'd7,          32'd6,          32'd42,         "mul_7x6");
        run_op(OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "mulhu_max");
        run_op(OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  "mul_max");
        run_op(OP_DIVU,  32'd100,        32'd7,          32'd14,         "divu_100_7");
        run_op(OP_REMU,  32'd100,        32'd7,          32'd2,          "remu_100_7");
        run_op(OP_DIVU,  32'h8000_0001,  32'hFFFF_FFFF,  32'd0,          "divu_msb");
        run_op(OP_DIVU,  32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  "divu_by0");
        run_op(OP_REMU,  32'h0000_1234,  32'd0,          32'h0000_1234,  "remu_by0");
`ifdef MDU_SIGNED_EN
        run_op(OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2");
        run_op(OP_REM,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2");
        run_op(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf");
        run_op(OP_REM,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf");
        run_op(OP_DIV,   32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  "div_m5_0");
        run_op(OP_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          "mulh_m1_m1");
`else
        run_op(OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  "div_as_divu");
        run_op(OP_MULH,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  "mulh_as_mulhu");
`endif

        // istart while busy is ignored and not queued
        start_op(OP_MUL, 32'd3, 32'd5);
        repeat (9) begin @(posedge iclk); @(negedge iclk); end
        istart = 1'b1;
        iop    = OP_DIVU;
        isrc_a = 32'd100;
        isrc_b = 32'd7;
        @(posedge iclk);
        @(negedge iclk);
        istart = 1'b0;
        wait_done(10, k);
        check("busy_start:latency", 32'(k), 32'(LAT_EDGE));
        check("busy_start:result", oresult, 32'd15);
        watch_quiet(45, pulses);
        check("busy_start:no_extra_valid", 32'(pulses), 32'd0);
        check("busy_start:idle", 32'(obusy), 32'd0);

        // iflush at edge 15 aborts, no ovalid, result unchanged
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (14) begin @(posedge iclk); @(negedge iclk); end
        iflush = 1'b1;
        @(posedge iclk);
        @(negedge iclk);
        iflush = 1'b0;
        check("flush:busy", 32'(obusy), 32'd0);
        check("flush:state", 32'(dbg_state), 32'(IDLE));
        watch_quiet(45, pulses);
        check("flush:no_valid", 32'(pulses), 32'd0);
        check("flush:result_held", oresult, 32'd15);

        // Reset asserted mid-ITER
        start_op(OP_MUL, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) begin @(posedge iclk); @(negedge iclk); end
        irst_n = 1'b0;
        #1;
        check("midrst:busy", 32'(obusy), 32'd0);
        check("midrst:valid", 32'(ovalid), 32'd0);
        check("midrst:result", oresult, 32'd0);
        check("midrst:alu_ctrl", 32'(oalu_ctrl), 32'(ADD_OP));
        check("midrst:alu_a", oalu_src_a, 32'd0);
        check("midrst:alu_b", oalu_src_b, 32'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        watch_quiet(45, pulses);
        check("midrst:no_valid", 32'(pulses), 32'd0);

        // Randomized ops against the reference model, back to back
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, ref_model(op, a, b), $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
